// File: rtl/spi_host_pkg.sv
// rtl/spi_host_pkg.sv - shared register map, bit indices and FSM encoding for spi_host_ctrl
package spi_host_pkg;

  // Register select values on addr
  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;
  localparam logic [1:0] ADDR_CLKDIV = 2'd3;

  // STATUS bit positions
  localparam int ST_TX_FULL  = 0;
  localparam int ST_TX_EMPTY = 1;
  localparam int ST_RX_FULL  = 2;
  localparam int ST_RX_EMPTY = 3;
  localparam int ST_ACTIVE   = 4;
  localparam int ST_RX_OVF   = 5;

  // CTRL bit positions; slave address occupies [CTRL_ADDR_LSB +: 4]
  localparam int CTRL_RUN      = 0;
  localparam int CTRL_CPOL     = 1;
  localparam int CTRL_CPHA     = 2;
  localparam int CTRL_IRQ_EN   = 3;
  localparam int CTRL_ADDR_LSB = 4;

  localparam logic [7:0] CTRL_RESET   = 8'h00;
  localparam logic [7:0] CLKDIV_RESET = 8'h01;

  typedef enum logic [1:0] {
    FSM_IDLE    = 2'd0,
    FSM_LAUNCH  = 2'd1,
    FSM_WAIT_HI = 2'd2,
    FSM_WAIT_LO = 2'd3
  } fsm_state_e;

  // Assemble the STATUS byte; unused upper bits read as zero
  function automatic logic [7:0] pack_status(input logic tx_full, input logic tx_empty,
                                             input logic rx_full, input logic rx_empty,
                                             input logic active, input logic rx_ovf);
    logic [7:0] s;
    s              = 8'h00;
    s[ST_TX_FULL]  = tx_full;
    s[ST_TX_EMPTY] = tx_empty;
    s[ST_RX_FULL]  = rx_full;
    s[ST_RX_EMPTY] = rx_empty;
    s[ST_ACTIVE]   = active;
    s[ST_RX_OVF]   = rx_ovf;
    return s;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO, power-of-two depth, push accepted when full if a pop coincides
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] s_tdata,
  input  logic             s_tvalid,
  output logic [WIDTH-1:0] m_tdata,
  output logic             m_tvalid,
  input  logic             m_tready,
  output logic             full
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign full     = (count_q == FULL_CNT);
  assign m_tvalid = (count_q != '0);
  assign m_tdata  = mem[rd_ptr_q];
  assign do_pop   = m_tvalid && m_tready;
  // A simultaneous pop frees the slot the push needs, so a full FIFO still accepts
  assign do_push  = s_tvalid && (!full || do_pop);

  // Storage array carries no reset; only occupied slots are ever read
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr_q] <= s_tdata;
  end

  // Pointers wrap naturally at DEPTH since DEPTH is a power of two
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/spi_host_ctrl.sv
// rtl/spi_host_ctrl.sv - CPU register front end feeding bytes to an SPI core through TX/RX FIFOs
module spi_host_ctrl
  import spi_host_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int SLAVES     = 1
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       we,
  input  logic       re,
  input  logic [1:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       irq,
  output logic       core_enable,
  output logic       core_cpol,
  output logic       core_cpha,
  output logic       core_cont,
  output logic [7:0] core_clk_div,
  output logic [3:0] core_addr,
  output logic [7:0] core_tx_data,
  input  logic       core_busy,
  input  logic [7:0] core_rx_data
);

  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("spi_host_ctrl: FIFO_DEPTH must be a power of two in 2..16");
  end
  if (SLAVES < 1 || SLAVES > 16) begin : g_bad_slaves
    $error("spi_host_ctrl: SLAVES must fit the 4-bit slave address");
  end

  fsm_state_e state_q;
  logic       core_enable_q;
  logic [7:0] ctrl_q;
  logic [7:0] clkdiv_q;
  logic [7:0] rdata_q;
  logic       rx_ovf_q;
  logic       irq_q;

  logic       tx_full, tx_valid, tx_empty;
  logic       rx_full, rx_valid, rx_empty;
  logic [7:0] tx_head, rx_head;
  logic       cpu_data_wr, cpu_data_rd, cpu_status_wr;
  logic       fsm_pop, fsm_capture, active;
  logic [7:0] status_byte;

  assign cpu_data_wr   = we && (addr == ADDR_DATA);
  assign cpu_data_rd   = re && (addr == ADDR_DATA);
  assign cpu_status_wr = we && (addr == ADDR_STATUS);
  assign tx_empty      = !tx_valid;
  assign rx_empty      = !rx_valid;
  assign active        = (state_q != FSM_IDLE);
  assign fsm_pop       = (state_q == FSM_LAUNCH);
  assign fsm_capture   = (state_q == FSM_WAIT_LO) && !core_busy;
  assign status_byte   = pack_status(tx_full, tx_empty, rx_full, rx_empty, active, rx_ovf_q);

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clock    (clock),
    .reset_n  (reset_n),
    .s_tdata  (wdata),
    .s_tvalid (cpu_data_wr),
    .m_tdata  (tx_head),
    .m_tvalid (tx_valid),
    .m_tready (fsm_pop),
    .full     (tx_full)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clock    (clock),
    .reset_n  (reset_n),
    .s_tdata  (core_rx_data),
    .s_tvalid (fsm_capture),
    .m_tdata  (rx_head),
    .m_tvalid (rx_valid),
    .m_tready (cpu_data_rd),
    .full     (rx_full)
  );

  // Transfer sequencer: launch one byte, wait for the core's busy pulse, capture on its fall
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= FSM_IDLE;
      core_enable_q <= 1'b0;
    end else begin
      case (state_q)
        FSM_IDLE: begin
          if (ctrl_q[CTRL_RUN] && !tx_empty && !core_busy) begin
            state_q       <= FSM_LAUNCH;
            core_enable_q <= 1'b1;
          end
        end
        FSM_LAUNCH: state_q <= FSM_WAIT_HI;
        FSM_WAIT_HI: begin
          if (core_busy) begin
            state_q       <= FSM_WAIT_LO;
            core_enable_q <= 1'b0;
          end
        end
        FSM_WAIT_LO: begin
          if (!core_busy) state_q <= FSM_IDLE;
        end
        default: begin
          state_q       <= FSM_IDLE;
          core_enable_q <= 1'b0;
        end
      endcase
    end
  end

  // CPU-writable configuration and the sticky overflow flag (a new overflow beats a clear)
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_q   <= CTRL_RESET;
      clkdiv_q <= CLKDIV_RESET;
      rx_ovf_q <= 1'b0;
    end else begin
      if (we && addr == ADDR_CTRL)   ctrl_q   <= wdata;
      if (we && addr == ADDR_CLKDIV) clkdiv_q <= wdata;
      if (fsm_capture && rx_full && !cpu_data_rd) rx_ovf_q <= 1'b1;
      else if (cpu_status_wr && wdata[ST_RX_OVF]) rx_ovf_q <= 1'b0;
    end
  end

  // Registered read data; holds its value when no read is issued
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rdata_q <= 8'h00;
    end else if (re) begin
      case (addr)
        ADDR_DATA:   rdata_q <= rx_empty ? 8'h00 : rx_head;
        ADDR_STATUS: rdata_q <= status_byte;
        ADDR_CTRL:   rdata_q <= ctrl_q;
        default:     rdata_q <= clkdiv_q;
      endcase
    end
  end

  // Interrupt: received data waiting, or all sent and the sequencer has gone quiet
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) irq_q <= 1'b0;
    else          irq_q <= ctrl_q[CTRL_IRQ_EN] && (!rx_empty || (tx_empty && !active));
  end

  assign rdata        = rdata_q;
  assign irq          = irq_q;
  assign core_enable  = core_enable_q;
  assign core_cpol    = ctrl_q[CTRL_CPOL];
  assign core_cpha    = ctrl_q[CTRL_CPHA];
  assign core_cont    = 1'b0;
  assign core_clk_div = clkdiv_q;
  assign core_addr    = ctrl_q[CTRL_ADDR_LSB +: 4];
  assign core_tx_data = tx_head;

endmodule
